// File: rtl/instr_issuer_if.sv
// Core instruction/result bus between the issuer and the 16-bit ALU/register-file core.
//   inst_out : 16-bit instruction word presented on the core pins ({uio_in, ui_in})
//   res_in   : 8-bit ALU result returned by the core
//   zero_in  : zero flag returned by the core
// master modport is the issuer side; slave modport is the core side.
interface instr_issuer_if;
  logic [15:0] inst_out;
  logic [7:0]  res_in;
  logic        zero_in;

  modport master (output inst_out, input res_in, input zero_in);
  modport slave  (input inst_out, output res_in, output zero_in);
endinterface

// File: rtl/instr_issuer.sv
// instr_issuer: program-driven instruction source for the pin-fed ALU/register-file core.
// A small program memory is loaded while idle. On start, each instruction is driven
// onto the core bus for HOLD_CYCLES cycles. The core's {zero, result} is then captured
// into a result buffer at the index of that instruction.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   prog_we/addr/data  program load port (accepted only when idle)
//   prog_len        instructions to run (sampled on start, clamped to DEPTH, 0 -> immediate done)
//   start           run request pulse (accepted only when idle)
//   core            instr_issuer_if.master: inst_out to core, res_in/zero_in from core
//   busy            high while issuing/holding
//   done            one-cycle pulse at end of run
//   abort           sticky early-termination flag, cleared by start
//   count           instructions completed in the last/current run
//   rd_addr/rd_data combinational result buffer read, {zero, result}
//
// Optional feature macro: ASSERT_NZ_EN
//   When defined, opcode 3'b101 ends the run early (with abort=1) if the core reports zero.
module instr_issuer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_CYCLES = 2,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  instr_issuer_if.master core,
  output logic          busy,
  output logic          done,
  output logic          abort,
  output logic [AW:0]   count,
  input  logic [AW-1:0] rd_addr,
  output logic [8:0]    rd_data
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [2:0] OP_REG_WRITE = 3'b011;
  localparam logic [2:0] OP_ASSERT_NZ = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   prog_mem [DEPTH];
  logic [8:0]    res_mem  [DEPTH];

  logic [AW-1:0] pc_q;
  logic [HW-1:0] hcnt_q;
  logic [15:0]   instr_q;
  logic [AW:0]   len_q;
  logic [AW:0]   count_q;

  logic          start_ok;
  logic          last_hold;
  logic          pc_last;
  logic          stop_early;
  logic [AW:0]   pc_next_ext;
  logic [AW:0]   len_clamped;

  assign start_ok    = (state_q == S_IDLE) && start;
  assign last_hold   = (state_q == S_HOLD) && (hcnt_q == HW'(HOLD_CYCLES - 1));
  assign pc_next_ext = {1'b0, pc_q} + (AW+1)'(1);
  assign pc_last     = (pc_next_ext == len_q);
  assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;

`ifdef ASSERT_NZ_EN
  logic abort_q;

  assign stop_early = last_hold && (instr_q[2:0] == OP_ASSERT_NZ) && core.zero_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
    end else if (start_ok) begin
      abort_q <= 1'b0;
    end else if (stop_early) begin
      abort_q <= 1'b1;
    end
  end

  assign abort = abort_q;
`else
  assign stop_early = 1'b0;
  assign abort      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (prog_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD: begin
        if (last_hold) begin
          state_d = (stop_early || pc_last) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      hcnt_q  <= '0;
      instr_q <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      if (start_ok) begin
        pc_q    <= '0;
        count_q <= '0;
        len_q   <= len_clamped;
      end
      if (state_q == S_ISSUE) begin
        instr_q <= prog_mem[pc_q];
        hcnt_q  <= '0;
      end
      if (state_q == S_HOLD) begin
        if (!last_hold) begin
          hcnt_q <= hcnt_q + HW'(1);
        end else begin
          count_q <= count_q + (AW+1)'(1);
          // pc only advances when another instruction follows, so it never wraps
          if (!stop_early && !pc_last) begin
            pc_q <= pc_q + AW'(1);
          end
        end
      end
    end
  end

  // Memories are intentionally not reset.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && prog_we) begin
      prog_mem[prog_addr] <= prog_data;
    end
    if (last_hold) begin
      res_mem[pc_q] <= {core.zero_in, core.res_in};
    end
  end

  // Register writes present opcode 000 until the last hold cycle so the core
  // performs exactly one write, after its operands have settled.
  always_comb begin
    core.inst_out = '0;
    if (state_q == S_HOLD) begin
      core.inst_out = instr_q;
      if ((instr_q[2:0] == OP_REG_WRITE) && !last_hold) begin
        core.inst_out[2:0] = 3'b000;
      end
    end
  end

  assign busy    = (state_q == S_ISSUE) || (state_q == S_HOLD);
  assign done    = (state_q == S_DONE);
  assign count   = count_q;
  assign rd_data = res_mem[rd_addr];

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Program-driven instruction source for the 16-bit pin-fed ALU/register-file core.
- Holds a small loadable program and drives one instruction at a time onto the core's instruction bus.
- Captures the core's 8-bit result and zero flag per instruction into a result buffer.
- Sits on the bench/host side of the core pins. It replaces manual pin wiggling with a sequenced, timed issue.

Parameters:
DEPTH, 16, program and result buffer entries (power of 2, 2..64); AW = log2(DEPTH)
HOLD_CYCLES, 2, cycles each instruction is driven before its result is sampled (min 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
prog_we  in  1  program write strobe (ignored unless FSM in IDLE)
prog_addr  in  AW  program write address
prog_data  in  16  instruction word: [2:0] opcode, [6:3] func, [9:7] rs2, [12:10] rs1, [15:13] rd
prog_len  in  AW+1  number of instructions to run, sampled on start; 0 means immediate DONE
start  in  1  one-cycle pulse, accepted only in IDLE
inst_out  out  16  instruction to core ({uio_in, ui_in})
res_in  in  8  core ALU result
zero_in  in  1  core zero flag
busy  out  1  high in ISSUE/HOLD
done  out  1  one-cycle pulse at end of run
abort  out  1  sticky; set when run ended via optional feature, cleared by start
count  out  AW+1  instructions completed in last/current run
rd_addr  in  AW  result buffer read address
rd_data  out  9  {zero, result} for rd_addr, combinational read

Behaviour:
- Reset (async, rst_n low): FSM=IDLE, inst_out=16'h0000, busy=0, done=0, abort=0, count=0, pc=0, hold counter=0. Program and result memories are not reset. Reset mid-run abandons the run immediately, without a done pulse.
- States: IDLE -> ISSUE on start with prog_len!=0. IDLE -> DONE on start with prog_len==0.
- ISSUE, 1 cycle: latch prog_mem[pc] into the instruction register. Hold counter = 0. Go to HOLD.
- HOLD, HOLD_CYCLES cycles, counter 0..HOLD_CYCLES-1:
  - inst_out = latched word, except opcode 3'b011 (register write). For that opcode, inst_out[2:0] is forced to 3'b000 on all but the final hold cycle. This gives exactly one write, using settled operands.
  - On the final hold cycle, at the clock edge: result_mem[pc] <= {zero_in, res_in}; count <= count+1.
  - If pc+1 == prog_len, go to DONE. Otherwise pc <= pc+1 and go to ISSUE.
- DONE, 1 cycle: done=1, inst_out=16'h0000, then IDLE.
- IDLE/DONE drive inst_out = 16'h0000 (opcode 000, no write).
- Per-instruction latency: 1 + HOLD_CYCLES cycles. A run of N instructions takes N*(1+HOLD_CYCLES)+1 cycles from start to done.
- start while busy: ignored. prog_we while busy: ignored (program memory is stable during a run).
- start sample clears count and abort, and sets pc=0.
- prog_len > DEPTH: clamped to DEPTH. pc never wraps mid-run.
- rd_data reads the result buffer at any time. An entry written on the same edge appears the next cycle.

Optional Feature:
Macro ASSERT_NZ_EN.
- Defined: opcode 3'b101 is an "assert nonzero" instruction. It is issued and sampled normally. If the sampled zero_in==1, the FSM goes to DONE after the capture, regardless of remaining instructions, and sets abort=1. count includes the failing instruction.
- Undefined: opcode 3'b101 is treated like any other instruction. abort is tied to 0.

Test Plan:
- Reset: assert rst_n=0 mid-HOLD -> inst_out=0, busy=0, done=0, count=0 immediately (async). No done pulse follows.
- Single AND, HOLD_CYCLES=2: load addr0=16'h0480 (rs1=1, rs2=1, func=0, op=000), prog_len=1, start -> inst_out=16'h0480 for 2 cycles. rd_data[0]=9'h001. done pulses at cycle 4 after start. count=1.
- Register write: load ADD rd=2, rs1=3, rs2=1, op=011, then XOR rd=0, rs1=2, rs2=2 -> first word shows opcode 000 on hold cycle 0 and 011 only on hold cycle 1. Result 0 captured = 8'h04, result 1 = {1, 8'h00}.
- Back-to-back 16 instructions: prog_len=16 -> done exactly 16*3+1 cycles after start. count=16. All 16 buffer entries written, pc does not wrap.
- Edge cases: prog_len=0 -> done next cycle, inst_out stays 0. start and prog_we during busy -> no effect on run or program.
- ASSERT_NZ_EN: program EQUAL(1,2) with op=101 at addr0, 3 more entries -> zero_in=1, so abort=1 and done after 1 instruction, count=1. Without the macro, the run completes with count=4 and abort=0.
